cnn_fmap_window_gen: RTL and testbench
======================================

# cnn_fmap_window_gen

Streaming sliding-window generator that feeds the channel-input accumulator stage of the CNN accelerator. It accepts one multi-channel pixel per valid beat in raster order and buffers KY-1 image lines. For every pixel that completes a full KX×KY neighbourhood (valid convolution, no padding), it emits the packed CI×KY×KX window on the `i_in_valid`/`i_in_fmap` bus the accumulator consumes.

## Interface
- CI, 3: channels per pixel
- KX, 3: kernel width
- KY, 3: kernel height
- I_F_BW, 8: bits per channel sample
- IW, 8: image width in pixels (≥ KX)
- IH, 8: image height in lines (≥ KY)
- C_BW, 4: column/row counter width (2^C_BW ≥ max(IW, IH))

- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- i_soft_reset  in  1  synchronous clear; frame restarts at (0,0)
- i_in_valid  in  1  pixel beat qualifier; no backpressure
- i_in_pixel  in  CI*I_F_BW  channel ch at bits [ch*I_F_BW +: I_F_BW]
- o_ot_valid  out  1  window valid, one-cycle pulse per window
- o_ot_fmap  out  CI*KX*KY*I_F_BW  packed window
- o_ot_row  out  C_BW  output row of the window (top-left line index)
- o_ot_col  out  C_BW  output column of the window (top-left pixel index)
- o_frame_done  out  1  pulse coincident with the last window of a frame

## Operation
- Input position counters col (0..IW-1) and row (0..IH-1) advance only on `i_in_valid`.
  - col wraps IW-1→0 and then row increments.
  - On (IH-1, IW-1), both wrap to 0 and the next beat starts a new frame.
- Line buffers hold the previous KY-1 lines, CI*I_F_BW per entry, written at index col on each valid beat. Their contents are never cleared; only counters gate their use.
- Window register holds KX columns × KY rows.
  - On each valid beat it shifts one column left.
  - The new rightmost column is {line buffers at col, current pixel}.
- Packing:
  - Sample (ch, ky, kx) sits at bit offset ((ch*KY + ky)*KX + kx)*I_F_BW.
  - ky=0 is the oldest (top) line; kx=0 is the leftmost (oldest) column.
  - (ch, KY-1, KX-1) is the pixel just received.
- Emission condition: a beat at (r, c) with r ≥ KY-1 and c ≥ KX-1.
  - The window covers lines r-KY+1..r and columns c-KX+1..c.
  - o_ot_row = r-KY+1, o_ot_col = c-KX+1.
- Windows per frame: (IH-KY+1)*(IW-KX+1). No window ever spans a line boundary.
- Idle cycles (`i_in_valid`=0) hold all state; o_ot_valid=0; o_ot_fmap/row/col keep their last values.

## Timing
- Latency: input beat at cycle t → o_ot_valid, o_ot_fmap, o_ot_row, o_ot_col registered at t+1.
- o_frame_done asserts at t+1 for the beat at (IH-1, IW-1), together with that beat's o_ot_valid.
- Throughput: one window per cycle when inputs are back-to-back; no stalls or bubbles inserted.
- Reset values: o_ot_valid=0, o_frame_done=0, o_ot_fmap=0, o_ot_row=0, o_ot_col=0; counters 0; window register 0.
- `i_soft_reset` has the same effect as reset, applied on the clock edge. It has priority over a simultaneous `i_in_valid`; that beat is dropped.
- Soft reset mid-frame:
  - The partial frame is abandoned and no o_frame_done is issued.
  - The next frame re-fills the lines, and its first window appears only at (KY-1, KX-1).
- Back-to-back frames: the first beat of frame n+1 may directly follow the last beat of frame n. Stale line data is never emitted, because rows < KY-1 produce no windows.

## Test plan
- Defaults, one frame. Pixel (r,c) channel ch = (r*8+c+ch*64) mod 256, fed continuously.
  - Exactly 36 windows; first is at input beat 18 plus 1 cycle.
  - First window ch0 samples in order ky,kx: {0,1,2,8,9,10,16,17,18}; ch1 = those values +64.
  - o_ot_row=0, o_ot_col=0.
- Same frame with `i_in_valid` deasserted on random ~50% of cycles → identical window sequence; every o_ot_valid exactly one cycle after its emitting beat.
- Line-boundary check: no window at beats (r, 0) or (r, 1).
  - Window at (3,2) has o_ot_row=1, o_ot_col=0; ch0 = {8,9,10,16,17,18,24,25,26}.
- Frame end: o_frame_done asserted only with the window at o_ot_row=5, o_ot_col=5 (ch0 last sample 63). A second, immediately following frame reproduces the same 36 windows.
- Soft reset at input beat 30, with a valid beat on the same cycle:
  - That beat is dropped, outputs are zero next cycle, and no o_frame_done.
  - A fresh frame then yields first window {0,1,2,8,9,10,16,17,18}.
- Async reset_n asserted mid-window-stream → all outputs 0 immediately. After release, behaviour matches the first scenario.

Source files
------------

// File: rtl/cnn_fmap_window_gen.sv
// Streaming KXxKY sliding-window generator: buffers KY-1 lines and emits a
// packed CIxKYxKX window for every pixel that completes a valid neighbourhood.
module cnn_fmap_window_gen #(
  parameter int CI     = 3,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int IW     = 8,
  parameter int IH     = 8,
  parameter int C_BW   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_soft_reset,
  input  logic                          i_in_valid,
  input  logic [CI*I_F_BW-1:0]          i_in_pixel,
  output logic                          o_ot_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]    o_ot_fmap,
  output logic [C_BW-1:0]               o_ot_row,
  output logic [C_BW-1:0]               o_ot_col,
  output logic                          o_frame_done
);

  localparam int PIX_W = CI * I_F_BW;
  localparam int WIN_W = CI * KX * KY * I_F_BW;
  localparam int IDX_W = (IW > 1) ? $clog2(IW) : 1;
  localparam logic [C_BW-1:0] COL_LAST  = C_BW'(IW - 1);
  localparam logic [C_BW-1:0] ROW_LAST  = C_BW'(IH - 1);
  localparam logic [C_BW-1:0] COL_FIRST = C_BW'(KX - 1);
  localparam logic [C_BW-1:0] ROW_FIRST = C_BW'(KY - 1);

  typedef logic [KY-1:0][KX-1:0][PIX_W-1:0] win_t;

  logic [C_BW-1:0]  col;
  logic [C_BW-1:0]  row;
  logic [IDX_W-1:0] idx;
  win_t             win;
  win_t             win_next;
  logic             beat;
  logic             emit;
  logic             last;
  logic [PIX_W-1:0] lb [0:KY-2][0:IW-1];

  // Reorder the window into channel-major (ch, ky, kx) sample order.
  function automatic logic [WIN_W-1:0] pack_window(input win_t w);
    pack_window = '0;
    for (int ch = 0; ch < CI; ch++)
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX; kx++)
          pack_window[((ch*KY + ky)*KX + kx)*I_F_BW +: I_F_BW] = w[ky][kx][ch*I_F_BW +: I_F_BW];
  endfunction

  assign idx  = col[IDX_W-1:0];
  assign beat = i_in_valid & ~i_soft_reset;
  assign emit = beat && (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign last = (col == COL_LAST) && (row == ROW_LAST);

  always_comb begin
    win_next = win;
    for (int ky = 0; ky < KY; ky++)
      for (int kx = 0; kx < KX - 1; kx++)
        win_next[ky][kx] = win[ky][kx+1];
    for (int ky = 0; ky < KY - 1; ky++)
      win_next[ky][KX-1] = lb[ky][idx];
    win_next[KY-1][KX-1] = i_in_pixel;
  end

  // Stage p0 -> p1: counters, window register and registered window outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      win          <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
      o_ot_row     <= '0;
      o_ot_col     <= '0;
    end else if (i_soft_reset) begin
      col          <= '0;
      row          <= '0;
      win          <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
      o_ot_row     <= '0;
      o_ot_col     <= '0;
    end else begin
      o_ot_valid   <= emit;
      o_frame_done <= emit && last;
      if (i_in_valid) begin
        win <= win_next;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (emit) begin
        o_ot_fmap <= pack_window(win_next);
        o_ot_row  <= row - ROW_FIRST;
        o_ot_col  <= col - COL_FIRST;
      end
    end
  end

  // Line buffers are never cleared; the row counter keeps stale lines out of windows.
  always_ff @(posedge clk) begin
    if (beat) begin
      for (int k = 0; k < KY - 2; k++)
        lb[k][idx] <= lb[k+1][idx];
      lb[KY-2][idx] <= i_in_pixel;
    end
  end

endmodule

// File: tb/tb_cnn_fmap_window_gen.sv
// Directed bench for cnn_fmap_window_gen: full frames, gapped input,
// back-to-back frames, soft reset and asynchronous reset mid-stream.
module tb_cnn_fmap_window_gen;
  localparam int CI = 3, KX = 3, KY = 3, I_F_BW = 8, IW = 8, IH = 8, C_BW = 4;
  localparam int FW = CI * KX * KY * I_F_BW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_soft_reset;
  logic              i_in_valid;
  logic [CI*I_F_BW-1:0] i_in_pixel;
  logic              o_ot_valid;
  logic [FW-1:0]     o_ot_fmap;
  logic [C_BW-1:0]   o_ot_row;
  logic [C_BW-1:0]   o_ot_col;
  logic              o_frame_done;

  int            n_vec = 0;
  int            n_err = 0;
  int            win_cnt = 0;
  logic [FW-1:0] last_fmap = '0;

  cnn_fmap_window_gen #(.CI(CI), .KX(KX), .KY(KY), .I_F_BW(I_F_BW),
                        .IW(IW), .IH(IH), .C_BW(C_BW)) dut (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset),
    .i_in_valid(i_in_valid), .i_in_pixel(i_in_pixel),
    .o_ot_valid(o_ot_valid), .o_ot_fmap(o_ot_fmap), .o_ot_row(o_ot_row),
    .o_ot_col(o_ot_col), .o_frame_done(o_frame_done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [CI*I_F_BW-1:0] pix(input int r, input int c);
    pix = '0;
    for (int ch = 0; ch < CI; ch++)
      pix[ch*I_F_BW +: I_F_BW] = 8'((r*8 + c + ch*64) % 256);
  endfunction

  function automatic logic [FW-1:0] exp_win(input int r, input int c);
    exp_win = '0;
    for (int ch = 0; ch < CI; ch++)
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX; kx++)
          exp_win[((ch*KY + ky)*KX + kx)*I_F_BW +: I_F_BW] =
            8'(((r - KY + 1 + ky)*8 + (c - KX + 1 + kx) + ch*64) % 256);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 256'(o_ot_valid), 256'(0));
    check({tag, "_done"},  256'(o_frame_done), 256'(0));
    check({tag, "_fmap"},  256'(o_ot_fmap), 256'(0));
    check({tag, "_row"},   256'(o_ot_row), 256'(0));
    check({tag, "_col"},   256'(o_ot_col), 256'(0));
  endtask

  // Feeds beats 0..nbeats-1 of a frame from a negedge, checking each result one cycle later.
  task automatic run_frame(input bit gaps, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      int r;
      int c;
      bit ev;
      r = b / IW;
      c = b % IW;
      if (gaps && $urandom_range(0, 1) == 1) begin
        i_in_valid = 1'b0;
        i_in_pixel = 24'($urandom);
        @(negedge clk);
        check("idle_valid", 256'(o_ot_valid), 256'(0));
        check("idle_fmap", 256'(o_ot_fmap), 256'(last_fmap));
      end
      i_in_valid = 1'b1;
      i_in_pixel = pix(r, c);
      @(negedge clk);
      ev = (r >= KY - 1) && (c >= KX - 1);
      check("valid", 256'(o_ot_valid), 256'(ev));
      check("frame_done", 256'(o_frame_done), 256'(ev && r == IH - 1 && c == IW - 1));
      if (ev) begin
        win_cnt++;
        last_fmap = exp_win(r, c);
        check("fmap", 256'(o_ot_fmap), 256'(last_fmap));
        check("row", 256'(o_ot_row), 256'(r - KY + 1));
        check("col", 256'(o_ot_col), 256'(c - KX + 1));
        if (r == 2 && c == 2) begin
          check("first_ch0", 256'(o_ot_fmap[71:0]),
                256'({8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}));
          check("first_ch1", 256'(o_ot_fmap[143:72]),
                256'({8'd82, 8'd81, 8'd80, 8'd74, 8'd73, 8'd72, 8'd66, 8'd65, 8'd64}));
        end
        if (r == 3 && c == 2)
          check("r3c2_ch0", 256'(o_ot_fmap[71:0]),
                256'({8'd26, 8'd25, 8'd24, 8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8}));
        if (r == 7 && c == 7)
          check("last_sample", 256'(o_ot_fmap[71:64]), 256'(63));
      end
    end
    i_in_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
    i_in_pixel   = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    win_cnt = 0;
    run_frame(1'b0, 64);
    check("windows_frame1", 256'(win_cnt), 256'(36));
    win_cnt = 0;
    run_frame(1'b0, 64);
    check("windows_frame2", 256'(win_cnt), 256'(36));
    win_cnt = 0;
    run_frame(1'b1, 64);
    check("windows_gapped", 256'(win_cnt), 256'(36));

    run_frame(1'b0, 30);
    i_in_valid   = 1'b1;
    i_in_pixel   = pix(3, 6);
    i_soft_reset = 1'b1;
    @(negedge clk);
    check_zero("soft_reset");
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
    last_fmap    = '0;
    @(negedge clk);
    check("post_sr_valid", 256'(o_ot_valid), 256'(0));
    win_cnt = 0;
    run_frame(1'b0, 64);
    check("windows_after_sr", 256'(win_cnt), 256'(36));

    run_frame(1'b0, 29);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    last_fmap = '0;
    win_cnt = 0;
    run_frame(1'b0, 64);
    check("windows_after_rst", 256'(win_cnt), 256'(36));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
